neural_soc_sysid_checker: RTL and testbench

Avalon-MM master that sits directly downstream of the system-ID slave. After reset it reads the ID word (address 0) and the timestamp word (address 1) and compares both against build-time expected values. It reports pass/fail and gates the neural accelerator with `accel_enable`, so the accelerator never runs against a mismatched FPGA image. Software can request a recheck with `start`.

---
 rtl/neural_soc_sysid_pkg.sv | 31 +++
 rtl/neural_soc_avm_single_read.sv | 112 +++++++++++
 rtl/neural_soc_sysid_checker.sv | 177 +++++++++++++++++
 tb/tb_neural_soc_sysid_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neural_soc_sysid_pkg.sv
// rtl/neural_soc_sysid_pkg.sv - shared types and constants for the sysid checker
package neural_soc_sysid_pkg;

  // Check sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    COMPARE,
    PASS,
    FAIL
  } check_state_t;

  // Phases of a single Avalon-MM word read
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_REQ,
    PH_LAT
  } rd_phase_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ID      = 2'd1;
  localparam logic [1:0] FC_TS      = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/neural_soc_avm_single_read.sv
// rtl/neural_soc_avm_single_read.sv - one-word Avalon-MM read with latency and timeout counting
module neural_soc_avm_single_read
  import neural_soc_sysid_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rd_en,
  input  logic        rd_addr,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        rd_accept,
  output logic        rd_done,
  output logic        rd_timeout,
  output logic [31:0] rd_data
);

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  rd_phase_t  phase_q, phase_d;
  logic       read_q, read_d;
  logic       addr_q, addr_d;
  logic [9:0] tmo_q, tmo_d;
  logic [1:0] lat_q, lat_d;
  logic       accept;
  logic       tmo_hit;
  logic       lat_hit;
  logic       launch;

  // Handshake decode; an accept on the limit edge is not a timeout
  always_comb begin
    accept     = read_q & ~avm_waitrequest;
    tmo_hit    = read_q & avm_waitrequest & (tmo_q == TMO_LAST);
    lat_hit    = (phase_q == PH_LAT) & (lat_q == 2'd0);
    rd_accept  = accept;
    rd_done    = (READ_LATENCY == 0) ? accept : lat_hit;
    rd_timeout = tmo_hit;
    rd_data    = avm_readdata;
  end

  // Phase sequencing; a new read may launch on the edge that finishes the previous one
  always_comb begin
    phase_d = phase_q;
    read_d  = read_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    lat_d   = lat_q;
    launch  = 1'b0;
    case (phase_q)
      PH_IDLE: launch = rd_en;
      PH_REQ: begin
        if (accept) begin
          phase_d = PH_IDLE;
          read_d  = 1'b0;
          if (READ_LATENCY == 0) begin
            launch = rd_en;
          end else begin
            phase_d = PH_LAT;
            lat_d   = LAT_LAST;
          end
        end else if (tmo_hit) begin
          // Drop the request for one cycle; the owner decides whether to retry
          phase_d = PH_IDLE;
          read_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      PH_LAT: begin
        if (lat_hit) begin
          phase_d = PH_IDLE;
          launch  = rd_en;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    if (launch) begin
      phase_d = PH_REQ;
      read_d  = 1'b1;
      addr_d  = rd_addr;
      tmo_d   = '0;
    end
  end

  // Read-side state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      read_q  <= 1'b0;
      addr_q  <= SYSID_ADDR_ID;
      tmo_q   <= '0;
      lat_q   <= '0;
    end else begin
      phase_q <= phase_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;

endmodule

// File: rtl/neural_soc_sysid_checker.sv
// rtl/neural_soc_sysid_checker.sv - sysid/timestamp check sequencer gating the accelerator
module neural_soc_sysid_checker
  import neural_soc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1480800838,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        accel_enable
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

  check_state_t state_q, state_d;
  logic [2:0]   retry_q, retry_d;
  logic [31:0]  id_q, id_d;
  logic [31:0]  ts_q, ts_d;
  logic [1:0]   fail_code_q, fail_code_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         accel_q, accel_d;
  logic         rd_en;
  logic         rd_addr;
  logic         rd_accept;
  logic         rd_done;
  logic         rd_timeout;
  logic [31:0]  rd_data;

  neural_soc_avm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clock          (clock),
    .reset_n        (reset_n),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .rd_accept      (rd_accept),
    .rd_done        (rd_done),
    .rd_timeout     (rd_timeout),
    .rd_data        (rd_data)
  );

  // Check sequencing, retry accounting, capture and compare
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    id_d        = id_q;
    ts_d        = ts_q;
    fail_code_d = fail_code_q;
    case (state_q)
      IDLE: begin
        state_d = RD_ID;
        retry_d = '0;
      end
      RD_ID, RD_TS: begin
        if (rd_done) begin
          if (state_q == RD_ID) begin
            id_d    = rd_data;
            state_d = RD_TS;
          end else begin
            ts_d    = rd_data;
            state_d = COMPARE;
          end
        end else if (rd_accept) begin
          if (state_q == RD_ID) state_d = LAT_ID;
          else                  state_d = LAT_TS;
        end else if (rd_timeout) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d     = FAIL;
            fail_code_d = FC_TIMEOUT;
          end else begin
            retry_d = retry_q + 3'd1;
          end
        end
      end
      LAT_ID: begin
        if (rd_done) begin
          id_d    = rd_data;
          state_d = RD_TS;
        end
      end
      LAT_TS: begin
        if (rd_done) begin
          ts_d    = rd_data;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (id_q != EXPECTED_ID) begin
          state_d     = FAIL;
          fail_code_d = FC_ID;
        end else if (ts_q != EXPECTED_TS) begin
          state_d     = FAIL;
          fail_code_d = FC_TS;
        end else begin
          state_d = PASS;
        end
      end
      PASS, FAIL: begin
        if (start) begin
          state_d     = RD_ID;
          retry_d     = '0;
          fail_code_d = FC_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read requests follow the next state so the bus request is registered with the state
  always_comb begin
    rd_en   = (state_d == RD_ID) || (state_d == RD_TS);
    rd_addr = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // Status outputs are decoded from the next state and registered
  always_comb begin
    busy_d  = !((state_d == IDLE) || (state_d == PASS) || (state_d == FAIL));
    done_d  = (state_d == PASS) || (state_d == FAIL);
    pass_d  = (state_d == PASS);
    accel_d = pass_d & ~busy_d;
  end

  // Checker state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      id_q        <= '0;
      ts_q        <= '0;
      fail_code_q <= FC_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      accel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      fail_code_q <= fail_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      accel_q     <= accel_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_code    = fail_code_q;
  assign id_value     = id_q;
  assign ts_value     = ts_q;
  assign accel_enable = accel_q;

endmodule

// File: tb/tb_neural_soc_sysid_checker.sv
// tb/tb_neural_soc_sysid_checker.sv - directed bench for the sysid checker
module tb_neural_soc_sysid_checker;

  localparam logic [31:0] GOOD_TS = 32'd1480800838;
  localparam logic [31:0] BAD_TS  = 32'd1480800839;

  // Status word layout: {busy, done, pass, accel_enable, fail_code}
  localparam logic [31:0] EXP_RESET    = 32'b000000;
  localparam logic [31:0] EXP_BUSY     = 32'b100000;
  localparam logic [31:0] EXP_PASS     = 32'b011100;
  localparam logic [31:0] EXP_FAIL_ID  = 32'b010001;
  localparam logic [31:0] EXP_FAIL_TS  = 32'b010010;
  localparam logic [31:0] EXP_FAIL_TMO = 32'b010011;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Instance A: default parameters, programmable model
  logic        rst_n_a, start_a, wr_a, addr_a, read_a, busy_a, done_a, pass_a, accel_a;
  logic [1:0]  fc_a;
  logic [31:0] rdata_a, idv_a, tsv_a, id_a, ts_a, st_a, bus_a;
  // Instance B: READ_LATENCY=2 with stalls on the ID read
  logic        rst_n_bc, start_b, wr_b, addr_b, read_b, busy_b, done_b, pass_b, accel_b;
  logic [1:0]  fc_b;
  logic [31:0] rdata_b, idv_b, tsv_b, st_b, bus_b;
  // Instance C: slave that never accepts, TIMEOUT_CYCLES=4, MAX_RETRIES=1
  logic        start_c, wr_c, addr_c, read_c, busy_c, done_c, pass_c, accel_c, read_c_prev;
  logic [1:0]  fc_c;
  logic [31:0] rdata_c, idv_c, tsv_c, st_c, bus_c;
  int          pulses_c = 0;

  assign rdata_a = addr_a ? ts_a : id_a;
  assign rdata_b = addr_b ? GOOD_TS : 32'd0;
  assign rdata_c = addr_c ? GOOD_TS : 32'd0;
  assign st_a  = {26'd0, busy_a, done_a, pass_a, accel_a, fc_a};
  assign st_b  = {26'd0, busy_b, done_b, pass_b, accel_b, fc_b};
  assign st_c  = {26'd0, busy_c, done_c, pass_c, accel_c, fc_c};
  assign bus_a = {30'd0, read_a, addr_a};
  assign bus_b = {30'd0, read_b, addr_b};
  assign bus_c = {30'd0, read_c, addr_c};

  neural_soc_sysid_checker dut_a (
    .clock(clock), .reset_n(rst_n_a), .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wr_a), .avm_readdata(rdata_a), .start(start_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .fail_code(fc_a), .id_value(idv_a), .ts_value(tsv_a),
    .accel_enable(accel_a)
  );

  neural_soc_sysid_checker #(.READ_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(rst_n_bc), .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wr_b), .avm_readdata(rdata_b), .start(start_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .fail_code(fc_b), .id_value(idv_b), .ts_value(tsv_b),
    .accel_enable(accel_b)
  );

  neural_soc_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut_c (
    .clock(clock), .reset_n(rst_n_bc), .avm_address(addr_c), .avm_read(read_c),
    .avm_waitrequest(wr_c), .avm_readdata(rdata_c), .start(start_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .fail_code(fc_c), .id_value(idv_c), .ts_value(tsv_c),
    .accel_enable(accel_c)
  );

  // Count read attempts issued by instance C
  always @(posedge clock) begin
    if (read_c && !read_c_prev) pulses_c <= pulses_c + 1;
    read_c_prev <= read_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_bc = 1'b0; read_c_prev = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    wr_a = 1'b0; wr_b = 1'b1; wr_c = 1'b1;
    id_a = 32'd0; ts_a = GOOD_TS;
    repeat (2) @(posedge clock);
    #1;
    check("a_reset_status", st_a, EXP_RESET);
    check("a_reset_bus", bus_a, 32'd0);
    check("a_reset_id", idv_a, 32'd0);
    check("a_reset_ts", tsv_a, 32'd0);
    check("b_reset_status", st_b, EXP_RESET);
    check("c_reset_status", st_c, EXP_RESET);

    @(negedge clock);
    rst_n_a = 1'b1; rst_n_bc = 1'b1;
    tick(); // edge 1
    check("a_e1_bus", bus_a, 32'b10);
    check("a_e1_status", st_a, EXP_BUSY);
    check("c_e1_bus", bus_c, 32'b10);
    tick(); // edge 2
    check("a_e2_bus", bus_a, 32'b11);
    check("a_e2_id", idv_a, 32'd0);
    tick(); // edge 3
    check("a_e3_bus", bus_a, 32'b01);
    check("a_e3_status", st_a, EXP_BUSY);
    check("a_e3_ts", tsv_a, GOOD_TS);
    tick(); // edge 4
    check("a_e4_status", st_a, EXP_PASS);
    tick(); // edge 5
    check("c_e5_gap_bus", bus_c, 32'b00);
    tick(); // edge 6
    check("c_e6_retry_bus", bus_c, 32'b10);
    wr_b = 1'b0;
    tick(); // edge 7
    check("b_e7_latency_bus", bus_b, 32'b00);
    tick();
    tick(); // edge 9
    check("b_e9_ts_bus", bus_b, 32'b11);
    check("b_e9_id", idv_b, 32'd0);
    check("c_e9_status", st_c, EXP_BUSY);
    tick(); // edge 10
    check("c_e10_status", st_c, EXP_FAIL_TMO);
    tick();
    tick(); // edge 12
    check("b_e12_status", st_b, EXP_BUSY);
    tick(); // edge 13
    check("b_e13_status", st_b, EXP_PASS);
    check("b_e13_ts", tsv_b, GOOD_TS);
    repeat (5) tick();
    check("c_attempts", 32'(pulses_c), 32'd2);
    check("c_final_status", st_c, EXP_FAIL_TMO);
    check("c_final_bus", bus_c, 32'd0);
    check("c_values", idv_c | tsv_c, 32'd0);

    // Recheck with a wrong ID; a second start while busy must be ignored
    id_a = 32'd5;
    start_a = 1'b1;
    tick();
    check("a_start_edge_status", st_a, EXP_BUSY);
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check("a_id_mismatch_status", st_a, EXP_FAIL_ID);
    check("a_id_mismatch_id", idv_a, 32'd5);
    repeat (3) tick();
    check("a_no_queued_start", st_a, EXP_FAIL_ID);

    // Recheck from FAIL with a wrong timestamp
    id_a = 32'd0;
    ts_a = BAD_TS;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_restart_clears_code", st_a, EXP_BUSY);
    repeat (3) tick();
    check("a_ts_mismatch_status", st_a, EXP_FAIL_TS);
    check("a_ts_mismatch_ts", tsv_a, BAD_TS);

    // Good recheck, then reset while reading the timestamp
    ts_a = GOOD_TS;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    check("a_recheck_pass", st_a, EXP_PASS);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("a_mid_rd_ts_bus", bus_a, 32'b11);
    rst_n_a = 1'b0;
    #1;
    check("a_async_reset_status", st_a, EXP_RESET);
    check("a_async_reset_bus", bus_a, 32'd0);
    check("a_async_reset_vals", idv_a | tsv_a, 32'd0);
    @(negedge clock);
    rst_n_a = 1'b1;
    repeat (3) tick();
    check("a_rerun_e3_status", st_a, EXP_BUSY);
    tick();
    check("a_rerun_e4_status", st_a, EXP_PASS);
    check("b_done_idle", {31'd0, start_b | start_c}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
